// File: rtl/demux_router_if.sv
// Bundle of the demux_router stream signals: one producer side, two consumer ports.
// The slave modport is the router's view; the master modport is the environment's.
interface demux_router_if #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 16
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             signal;
    logic             in_ready;

    logic [WIDTH-1:0] out_1_data;
    logic             out_1_valid;
    logic             out_1_ready;
    logic [WIDTH-1:0] out_2_data;
    logic             out_2_valid;
    logic             out_2_ready;

    logic [CNT_W-1:0] count_1;
    logic [CNT_W-1:0] count_2;

    modport slave (
        input  in_data, in_valid, signal, out_1_ready, out_2_ready,
        output in_ready, out_1_data, out_1_valid, out_2_data, out_2_valid,
        output count_1, count_2
    );

    modport master (
        output in_data, in_valid, signal, out_1_ready, out_2_ready,
        input  in_ready, out_1_data, out_1_valid, out_2_data, out_2_valid,
        input  count_1, count_2
    );
endinterface

// File: rtl/demux_router.sv
// Registered 1:2 demultiplexer: each input word is steered by `signal` into one of two
// small FIFOs, so a stalled consumer never blocks words already buffered for the other.
module demux_router #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input logic           clk,
    input logic           reset,
    demux_router_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);

    typedef logic [WIDTH-1:0] word_t;

    word_t            mem_q    [2][DEPTH];
    word_t            mem_d    [2][DEPTH];
    logic [PTR_W-1:0] wr_ptr_q [2];
    logic [PTR_W-1:0] wr_ptr_d [2];
    logic [PTR_W-1:0] rd_ptr_q [2];
    logic [PTR_W-1:0] rd_ptr_d [2];
    logic [OCC_W-1:0] occ_q    [2];
    logic [OCC_W-1:0] occ_d    [2];
    word_t            data_q   [2];
    word_t            data_d   [2];
    logic [CNT_W-1:0] cnt_q    [2];
    logic [CNT_W-1:0] cnt_d    [2];
    logic [1:0]       full_q, full_d;
    logic [1:0]       valid_q, valid_d;
    logic [1:0]       push, pop, out_ready;
    logic             in_ready;

    // NOTE: every variable gets a default at the top of always_comb so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        mem_d     = mem_q;
        out_ready = {bus.out_2_ready, bus.out_1_ready};
        // Readiness looks only at registered full flags: no pass-through on a full FIFO.
        in_ready  = bus.signal ? !full_q[1] : !full_q[0];
        push      = '0;
        push[bus.signal] = bus.in_valid && in_ready;
        for (int ch = 0; ch < 2; ch++) begin
            pop[ch]      = valid_q[ch] && out_ready[ch];
            wr_ptr_d[ch] = wr_ptr_q[ch];
            rd_ptr_d[ch] = rd_ptr_q[ch];
            cnt_d[ch]    = cnt_q[ch];
            occ_d[ch]    = occ_q[ch];
            if (push[ch]) begin
                mem_d[ch][wr_ptr_q[ch]] = bus.in_data;
                wr_ptr_d[ch]            = wr_ptr_q[ch] + 1'b1;
            end
            if (pop[ch]) begin
                rd_ptr_d[ch] = rd_ptr_q[ch] + 1'b1;
                cnt_d[ch]    = cnt_q[ch] + 1'b1;
            end
            case ({push[ch], pop[ch]})
                2'b10:   occ_d[ch] = occ_q[ch] + 1'b1;
                2'b01:   occ_d[ch] = occ_q[ch] - 1'b1;
                default: occ_d[ch] = occ_q[ch];
            endcase
            full_d[ch]  = (occ_d[ch] == FULL_OCC);
            valid_d[ch] = (occ_d[ch] != '0);
            // Output word is registered; when the FIFO drains it keeps the last popped word.
            data_d[ch]  = valid_d[ch] ? mem_d[ch][rd_ptr_d[ch]] : data_q[ch];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples the
    // values from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '{default: '0};
            rd_ptr_q <= '{default: '0};
            occ_q    <= '{default: '0};
            data_q   <= '{default: '0};
            cnt_q    <= '{default: '0};
            full_q   <= '0;
            valid_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            data_q   <= data_d;
            cnt_q    <= cnt_d;
            full_q   <= full_d;
            valid_q  <= valid_d;
        end
    end

    // NOTE: storage is not reset; a slot is only ever read after it has been written,
    // and the pointers/occupancy alone define what is valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign bus.in_ready    = in_ready;
    assign bus.out_1_data  = data_q[0];
    assign bus.out_1_valid = valid_q[0];
    assign bus.out_2_data  = data_q[1];
    assign bus.out_2_valid = valid_q[1];
    assign bus.count_1     = cnt_q[0];
    assign bus.count_2     = cnt_q[1];
endmodule

// File: tb/tb_demux_router.sv
// Directed bench for demux_router: routing, backpressure, independence, push/pop overlap,
// pointer/counter wrap (CNT_W = 4) and mid-operation reset.
module tb_demux_router;
    localparam int WIDTH = 64;
    localparam int DEPTH = 2;
    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    demux_router_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    demux_router #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.in_valid    = 1'b0;
        bus.in_data     = '0;
        bus.signal      = 1'b0;
        bus.out_1_ready = 1'b0;
        bus.out_2_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        check("rst_v1", bus.out_1_valid, 0);
        check("rst_v2", bus.out_2_valid, 0);
        check("rst_d1", bus.out_1_data, 0);
        check("rst_d2", bus.out_2_data, 0);
        check("rst_c1", bus.count_1, 0);
        check("rst_c2", bus.count_2, 0);
        bus.signal = 1'b0; #1 check("rst_rdy_s0", bus.in_ready, 1);
        bus.signal = 1'b1; #1 check("rst_rdy_s1", bus.in_ready, 1);

        // Reset then route
        bus.out_1_ready = 1'b1;
        bus.out_2_ready = 1'b1;
        bus.in_valid = 1'b1; bus.signal = 1'b0; bus.in_data = 64'd10000;
        tick();
        check("route_v1", bus.out_1_valid, 1);
        check("route_d1", bus.out_1_data, 64'd10000);
        check("route_v2_idle", bus.out_2_valid, 0);
        bus.signal = 1'b1; bus.in_data = 64'd20000;
        tick();
        check("route_v1_done", bus.out_1_valid, 0);
        check("route_v2", bus.out_2_valid, 1);
        check("route_d2", bus.out_2_data, 64'd20000);
        check("route_c1", bus.count_1, 1);
        bus.in_valid = 1'b0;
        tick();
        check("route_v2_done", bus.out_2_valid, 0);
        check("route_v1_still", bus.out_1_valid, 0);
        check("route_c2", bus.count_2, 1);
        check("route_hold_d1", bus.out_1_data, 64'd10000);

        // Backpressure / full
        do_reset();
        bus.in_valid = 1'b1; bus.signal = 1'b0; bus.in_data = 64'd1;
        #1 check("bp_rdy_1", bus.in_ready, 1);
        tick();
        bus.in_data = 64'd2;
        #1 check("bp_rdy_2", bus.in_ready, 1);
        tick();
        bus.in_data = 64'd3;
        #1 check("bp_full_s0", bus.in_ready, 0);
        bus.signal = 1'b1;
        #1 check("bp_full_s1", bus.in_ready, 1);
        bus.in_valid = 1'b0; bus.signal = 1'b0;
        check("bp_head_v", bus.out_1_valid, 1);
        check("bp_head_d", bus.out_1_data, 64'd1);
        tick();
        check("bp_stable_v", bus.out_1_valid, 1);
        check("bp_stable_d", bus.out_1_data, 64'd1);
        check("bp_c1_zero", bus.count_1, 0);
        bus.out_1_ready = 1'b1;
        tick();
        check("bp_pop2_v", bus.out_1_valid, 1);
        check("bp_pop2_d", bus.out_1_data, 64'd2);
        check("bp_c1_one", bus.count_1, 1);
        tick();
        check("bp_empty", bus.out_1_valid, 0);
        check("bp_c1_two", bus.count_1, 2);

        // Independence: FIFO 1 full and stalled, FIFO 2 streams
        do_reset();
        bus.in_valid = 1'b1; bus.signal = 1'b0;
        bus.in_data = 64'hA; tick();
        bus.in_data = 64'hB; tick();
        bus.signal = 1'b0;
        #1 check("ind_full1", bus.in_ready, 0);
        bus.signal = 1'b1; bus.out_2_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.in_data = 64'(100 + i);
            tick();
            check("ind_v2", bus.out_2_valid, 1);
            check("ind_d2", bus.out_2_data, 64'(100 + i));
        end
        bus.in_valid = 1'b0;
        tick();
        check("ind_v2_done", bus.out_2_valid, 0);
        check("ind_c2", bus.count_2, 5);
        check("ind_c1", bus.count_1, 0);
        check("ind_head1", bus.out_1_data, 64'hA);

        // Simultaneous push and pop at occupancy 1
        do_reset();
        bus.in_valid = 1'b1; bus.signal = 1'b1; bus.in_data = 64'd200;
        tick();
        bus.out_2_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            bus.in_data = 64'(200 + i);
            tick();
            check("pp_v2", bus.out_2_valid, 1);
            check("pp_d2", bus.out_2_data, 64'(200 + i));
            check("pp_rdy", bus.in_ready, 1);
        end
        bus.in_valid = 1'b0;
        tick();
        check("pp_drain", bus.out_2_valid, 0);
        check("pp_c2", bus.count_2, 9);

        // Pointer wrap and counter wrap: 17 round trips on port 1, 5 on port 2
        do_reset();
        bus.out_1_ready = 1'b1; bus.out_2_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            bus.in_valid = 1'b1; bus.signal = 1'b0; bus.in_data = 64'(300 + i);
            tick();
            bus.in_valid = 1'b0;
            check("wrap_d1", bus.out_1_data, 64'(300 + i));
            tick();
            check("wrap_e1", bus.out_1_valid, 0);
        end
        check("wrap_c1", bus.count_1, 1);
        for (int i = 0; i < 2 * DEPTH + 1; i++) begin
            bus.in_valid = 1'b1; bus.signal = 1'b1; bus.in_data = 64'(400 + i);
            tick();
            bus.in_valid = 1'b0;
            check("wrap_d2", bus.out_2_data, 64'(400 + i));
            tick();
        end
        check("wrap_c2", bus.count_2, 5);

        // Reset mid-operation
        do_reset();
        bus.in_valid = 1'b1; bus.signal = 1'b0; bus.in_data = 64'h11; tick();
        bus.signal = 1'b1; bus.in_data = 64'h22; tick();
        check("mr_pre_v1", bus.out_1_valid, 1);
        check("mr_pre_v2", bus.out_2_valid, 1);
        reset = 1'b1;
        bus.signal = 1'b0; bus.in_data = 64'hDEAD;
        bus.out_1_ready = 1'b1; bus.out_2_ready = 1'b1;
        tick();
        reset = 1'b0;
        bus.in_valid = 1'b0;
        check("mr_v1", bus.out_1_valid, 0);
        check("mr_v2", bus.out_2_valid, 0);
        check("mr_c1", bus.count_1, 0);
        check("mr_c2", bus.count_2, 0);
        check("mr_d1", bus.out_1_data, 0);
        #1 check("mr_rdy_s0", bus.in_ready, 1);
        bus.signal = 1'b1;
        #1 check("mr_rdy_s1", bus.in_ready, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("mr_no_ghost", bus.out_1_valid, 0);
        end
        check("mr_c1_after", bus.count_1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/demux_router.md
# demux_router

Registered 1:2 demultiplexer for the 64-bit datapath. It takes one valid/ready input stream and steers each word to one of two destination ports based on a per-word `signal` bit. Each destination has its own small FIFO, so one stalled destination never blocks traffic already buffered for the other. It is the inverse of the 2:1 `mux`: where the mux merges two operand sources into one, this block fans a single producer (writeback or forwarding bus) out to two consumers.

## Interface
- `WIDTH`, default 64: data width of input and both outputs.
- `DEPTH`, default 2: entries per destination FIFO; must be a power of two and at least 2.
- `CNT_W`, default 16: width of the per-destination delivery counters.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset, sampled on the rising edge of `clk`.
- `in_data`  in  WIDTH  input word.
- `in_valid`  in  1  `in_data` and `signal` are valid.
- `signal`  in  1  destination select: 0 routes to out_1, 1 routes to out_2.
- `in_ready`  out  1  block can accept the current word.
- `out_1_data`  out  WIDTH  head of FIFO 1.
- `out_1_valid`  out  1  FIFO 1 is non-empty.
- `out_1_ready`  in  1  consumer 1 takes the head word.
- `out_2_data`, `out_2_valid`, `out_2_ready`: same meaning and widths, for FIFO 2.
- `count_1`  out  CNT_W  words delivered on out_1, i.e. pops from FIFO 1.
- `count_2`  out  CNT_W  words delivered on out_2.

## Operation
- Each FIFO is a circular buffer with write pointer, read pointer and occupancy. Pointers are log2(DEPTH) bits wide and wrap modulo DEPTH. Occupancy ranges over 0..DEPTH.
- `in_ready = signal ? !full_2 : !full_1`. This is a combinational function of `signal` and registered full flags only. It never depends on `in_valid` or on either `out_x_ready`.
- A push happens when `in_valid && in_ready`. The word is written to the FIFO selected by `signal` and is never written to the other FIFO.
- A pop on port x happens when `out_x_valid && out_x_ready`. It advances the read pointer and increments `count_x`.
- A simultaneous push and pop on the same FIFO leaves occupancy unchanged and advances both pointers.
- Full FIFO: `in_ready` is low for that destination, even if the consumer pops in the same cycle. There is no pass-through.
- Empty FIFO: `out_x_valid` is low. `out_x_data` is don't-care, but must hold the last popped word or 0 after reset, never X.
- `out_x_data` and `out_x_valid` must stay stable while `out_x_valid && !out_x_ready`.
- Order is preserved within each destination. There is no ordering guarantee between destinations.
- Counters wrap from 2^CNT_W-1 to 0 and do not saturate.
- Reset values: all pointers and occupancies 0, `out_1_valid`/`out_2_valid` 0, `out_1_data`/`out_2_data` 0, `count_1`/`count_2` 0. After reset `in_ready` is 1 for either value of `signal`.
- Reset mid-operation flushes both FIFOs. Buffered words are discarded and not counted. Any push or pop in the reset cycle is ignored.

## Timing
- Latency: a word pushed at edge N appears with `out_x_valid` = 1 in the cycle after edge N, and can be popped at edge N+1.
- Throughput: one push per cycle into any non-full FIFO, and one pop per cycle per port. The two ports pop independently in the same cycle.
- Full flag, `out_x_valid` and counters are registered. They update only at clock edges.
- `count_x` reflects a pop in the cycle after the popping edge.

## Test plan
- Reset then route: push 10000 with `signal`=0, then 20000 with `signal`=1, both consumers ready -> 10000 on out_1 and 20000 on out_2, each one cycle after its push; `count_1` = `count_2` = 1; the other port stays invalid throughout.
- Backpressure/full: `out_1_ready`=0, push 1, 2, 3 with `signal`=0 -> 1 and 2 accepted; `in_ready` goes 0 while `signal`=0 but stays 1 with `signal`=1; `out_1_data` holds 1 stably. Release `out_1_ready` -> 1 then 2 delivered in order.
- Independence: FIFO 1 full and stalled; stream 5 words with `signal`=1 and `out_2_ready`=1 -> all 5 delivered on out_2 back-to-back; `count_2` = 5; `count_1` = 0.
- Simultaneous push/pop: FIFO 2 at occupancy 1, push and pop in the same cycle for 8 cycles -> occupancy stays 1, values in order, no bubbles.
- Pointer and counter wrap: 2*DEPTH+1 round trips per port confirm pointer wrap. Force `count_1` near its limit (or use CNT_W=4) with 17 pops -> counter reads 1.
- Reset mid-operation: both FIFOs holding data, assert `reset` for 1 cycle while `in_valid`=1 -> next cycle both valids 0, counters 0, `in_ready` 1, and the word presented during reset never appears.
